// File: rtl/clk_rst_pkg.sv
// ---------------------------------------------------------------------------
// clk_rst_pkg
// Shared definitions for the clock-enable / reset sequencer:
//   - debug mode encodings driven on clk_rst_ctrl.mode
//   - sequencer state enumeration
//   - mode_to_state(): maps a mode request onto the state it selects
// ---------------------------------------------------------------------------
package clk_rst_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_HALT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        STEP = 2'b11
    } state_e;

    // The unused encoding 2'b11 parks the core, the safe choice for debug.
    function automatic state_e mode_to_state(input logic [1:0] mode);
        state_e st;
        case (mode)
            MODE_RUN:  st = RUN;
            MODE_STEP: st = STEP;
            MODE_HALT: st = HALT;
            default:   st = HALT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/tick_div.sv
// ---------------------------------------------------------------------------
// tick_div
// One programmable periodic tick channel. The counter advances only on
// enabled cycles; a tick is produced on the enabled cycle where the count has
// reached (or passed) the divisor, giving a period of div+1 enabled cycles.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   clr    in   synchronous clear of the counter and tick
//   en     in   advance enable (core clock enable)
//   div    in   DIV_W-bit divisor
//   tick   out  registered one-cycle tick
// ---------------------------------------------------------------------------
module tick_div #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next count and tick; >= compare makes a divisor cut below the current
    // count wrap on the next enabled cycle instead of running to overflow.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (en) begin
            if (cnt_q >= div) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + DIV_W'(1);
                tick_d = 1'b0;
            end
        end else begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// ---------------------------------------------------------------------------
// clk_rst_ctrl
// Clock-enable and reset sequencer between the board clock/reset and the core.
// Synchronises reset release, stretches the core reset for HOLD_CYCLES, then
// provides a run/halt/single-step core enable and NUM_CH periodic ticks.
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   sw_reset_req  in   synchronous request to re-run the hold sequence
//   mode          in   00 run, 01 halt, 10 step, 11 halt
//   step_req      in   rising edge requests one core_en cycle in step mode
//   div           in   channel i divisor at [i*DIV_W +: DIV_W]
//   rst_out_n     out  core reset, active-low, registered
//   ready         out  sequence complete (state not HOLD), registered
//   core_en       out  core clock enable, registered
//   tick          out  per-channel one-cycle tick, registered
//   cycle_count   out  (only with CYCLE_COUNT_EN) enabled-cycle counter
// Optional feature macro: CYCLE_COUNT_EN
// ---------------------------------------------------------------------------
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sw_reset_req,
    input  logic [1:0]              mode,
    input  logic                    step_req,
    input  logic [NUM_CH*DIV_W-1:0] div,
    output logic                    rst_out_n,
    output logic                    ready,
    output logic                    core_en,
    output logic [NUM_CH-1:0]       tick
`ifdef CYCLE_COUNT_EN
    ,
    output logic [31:0]             cycle_count
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic [HOLD_W-1:0]      hold_cnt_d;
    state_e                 state_q;
    state_e                 state_d;
    logic                   rst_out_n_q;
    logic                   rst_out_n_d;
    logic                   ready_q;
    logic                   ready_d;
    logic                   core_en_q;
    logic                   core_en_d;
    logic                   step_q;
    logic                   step_d;
    logic                   sync_s;
    logic                   step_rise_s;

    // Reset-release synchroniser: shifts in ones after reset deasserts.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_s      = sync_q[SYNC_STAGES-1];
    assign step_rise_s = step_req & ~step_q;

    // Sequencer next state, hold counter and registered output values.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        core_en_d  = 1'b0;
        step_d     = step_req;
        case (state_q)
            HOLD: begin
                if (sw_reset_req) begin
                    hold_cnt_d = '0;
                end else if (sync_s) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = mode_to_state(mode);
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            RUN, HALT, STEP: begin
                if (sw_reset_req) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else begin
                    state_d    = mode_to_state(mode);
                end
            end
            default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
        endcase

        // A step pulse needs STEP both now and next, so a step edge that
        // coincides with a mode change or a software reset is dropped.
        case (state_d)
            RUN:     core_en_d = 1'b1;
            STEP:    core_en_d = (state_q == STEP) && step_rise_s;
            default: core_en_d = 1'b0;
        endcase

        rst_out_n_d = (state_d != HOLD);
        ready_d     = (state_d != HOLD);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            hold_cnt_q  <= '0;
            state_q     <= HOLD;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
            core_en_q   <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            hold_cnt_q  <= hold_cnt_d;
            state_q     <= state_d;
            rst_out_n_q <= rst_out_n_d;
            ready_q     <= ready_d;
            core_en_q   <= core_en_d;
            step_q      <= step_d;
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign ready     = ready_q;
    assign core_en   = core_en_q;

    // Tick channels advance on the registered enable the core actually sees.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            tick_div #(
                .DIV_W (DIV_W)
            ) u_tick_div (
                .clock (clock),
                .reset (reset),
                .clr   (sw_reset_req),
                .en    (core_en_q),
                .div   (div[gi*DIV_W +: DIV_W]),
                .tick  (tick[gi])
            );
        end
    endgenerate

`ifdef CYCLE_COUNT_EN
    logic [31:0] cyc_q;
    logic [31:0] cyc_d;

    // Enabled-cycle counter; wraps naturally at 2^32.
    always_comb begin
        if (sw_reset_req) begin
            cyc_d = 32'd0;
        end else if (core_en_q) begin
            cyc_d = cyc_q + 32'd1;
        end else begin
            cyc_d = cyc_q;
        end
    end

    // Enabled-cycle counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q <= 32'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_rst_ctrl
// Self-checking bench for clk_rst_ctrl with default parameters
// (SYNC_STAGES=2, HOLD_CYCLES=16, NUM_CH=2, DIV_W=8).
// Optional feature macro: CYCLE_COUNT_EN
// ---------------------------------------------------------------------------
module tb_clk_rst_ctrl;

    logic        clock;
    logic        reset;
    logic        sw_reset_req;
    logic [1:0]  mode;
    logic        step_req;
    logic [15:0] div;
    logic        rst_out_n;
    logic        ready;
    logic        core_en;
    logic [1:0]  tick;
`ifdef CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    int total = 0;
    int bad   = 0;

    clk_rst_ctrl #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (16),
        .NUM_CH      (2),
        .DIV_W       (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sw_reset_req (sw_reset_req),
        .mode         (mode),
        .step_req     (step_req),
        .div          (div),
        .rst_out_n    (rst_out_n),
        .ready        (ready),
        .core_en      (core_en),
        .tick         (tick)
`ifdef CYCLE_COUNT_EN
        ,
        .cycle_count  (cycle_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mode;
        logic       step;
        logic       cen;
        logic [1:0] tick;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] m, input logic s,
                                input logic c, input logic [1:0] t);
        vec_t v;
        v.mode = m;
        v.step = s;
        v.cen  = c;
        v.tick = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    int n_hit;
    int tick_seen;
    logic [6:0] exp_tk;

    initial begin
        // Rows apply before edges 19..46 after reset release; div0=3, div1=0.
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b10)); // e19
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b10));
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b10));
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b11)); // e22 tick0
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b10));
        tbl.push_back(mk(2'b01, 1'b0, 1'b0, 2'b10)); // e24 halt
        tbl.push_back(mk(2'b01, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b01, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b00)); // e27 run again
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b10));
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b11)); // resumed count
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b10));
        tbl.push_back(mk(2'b11, 1'b0, 1'b0, 2'b10)); // e31 mode 11 = halt
        tbl.push_back(mk(2'b11, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b00));
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b10));
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 2'b11));
        tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b10)); // e36 step mode
        tbl.push_back(mk(2'b10, 1'b1, 1'b1, 2'b00)); // rising edge
        tbl.push_back(mk(2'b10, 1'b1, 1'b0, 2'b10)); // held
        tbl.push_back(mk(2'b10, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b10, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b10, 1'b1, 1'b0, 2'b00));
        tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b10, 1'b1, 1'b1, 2'b00)); // pulse 2
        tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b10));
        tbl.push_back(mk(2'b10, 1'b1, 1'b1, 2'b00)); // pulse 3
        tbl.push_back(mk(2'b10, 1'b0, 1'b0, 2'b11)); // e46

        reset        = 1'b0;
        sw_reset_req = 1'b0;
        mode         = 2'b00;
        step_req     = 1'b0;
        div          = 16'h0003;

        // Reset state.
        repeat (3) edge1();
        check("rst_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        check("rst_ready",     {31'd0, ready},     32'd0);
        check("rst_core_en",   {31'd0, core_en},   32'd0);
        check("rst_tick",      {30'd0, tick},      32'd0);

        // Release: outputs rise on edge 18.
        reset = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            edge1();
            check("rel_rst_out_n", {31'd0, rst_out_n}, (k == 18) ? 32'd1 : 32'd0);
            check("rel_core_en",   {31'd0, core_en},   (k == 18) ? 32'd1 : 32'd0);
            check("rel_tick",      {30'd0, tick},      32'd0);
        end
        check("rel_ready", {31'd0, ready}, 32'd1);

        // Table: run / halt / resume / step.
        for (int i = 0; i < tbl.size(); i++) begin
            mode     = tbl[i].mode;
            step_req = tbl[i].step;
            edge1();
            check($sformatf("vec%0d_core_en", i), {31'd0, core_en}, {31'd0, tbl[i].cen});
            check($sformatf("vec%0d_tick", i),    {30'd0, tick},    {30'd0, tbl[i].tick});
        end
        step_req = 1'b0;

        // Divisor cut 200 -> 2 while ch0 count is 50.
        mode = 2'b00;
        div  = 16'h00C8;
        tick_seen = 0;
        for (int k = 0; k < 51; k++) begin
            edge1();
            if (tick[0]) tick_seen++;
        end
        check("div200_no_tick", tick_seen, 32'd0);
        div = 16'h0002;
        exp_tk = 7'b1001001;
        for (int k = 6; k >= 0; k--) begin
            edge1();
            check("divcut_tick0", {31'd0, tick[0]}, {31'd0, exp_tk[k]});
        end

        // Software reset from RUN.
        sw_reset_req = 1'b1;
        edge1();
        sw_reset_req = 1'b0;
        check("sw_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        check("sw_ready",     {31'd0, ready},     32'd0);
        check("sw_core_en",   {31'd0, core_en},   32'd0);
        check("sw_tick",      {30'd0, tick},      32'd0);
        n_hit = 0;
        for (int n = 1; n <= 40; n++) begin
            edge1();
            if (rst_out_n) begin
                n_hit = n;
                break;
            end
        end
        check("sw_hold_len", n_hit, 32'd16);
        // Channel 0 restarts from zero: tick on the third enabled cycle.
        edge1();
        check("sw_clr_t1", {31'd0, tick[0]}, 32'd0);
        edge1();
        check("sw_clr_t2", {31'd0, tick[0]}, 32'd0);
        edge1();
        check("sw_clr_t3", {31'd0, tick[0]}, 32'd1);

        // Second request at hold cycle 8 restarts the hold.
        sw_reset_req = 1'b1;
        edge1();
        sw_reset_req = 1'b0;
        n_hit = 0;
        for (int n = 1; n <= 40; n++) begin
            sw_reset_req = (n == 8);
            edge1();
            sw_reset_req = 1'b0;
            if (rst_out_n) begin
                n_hit = n;
                break;
            end
        end
        check("sw_restart_len", n_hit, 32'd24);

        // Software reset coincident with a step edge: reset wins.
        mode = 2'b10;
        edge1();
        step_req     = 1'b1;
        sw_reset_req = 1'b1;
        edge1();
        step_req     = 1'b0;
        sw_reset_req = 1'b0;
        check("sw_step_core_en",   {31'd0, core_en},   32'd0);
        check("sw_step_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        n_hit = 0;
        for (int n = 1; n <= 40; n++) begin
            edge1();
            if (rst_out_n) begin
                n_hit = n;
                break;
            end
        end
        check("sw_step_hold_len", n_hit, 32'd16);
        check("sw_step_no_en",    {31'd0, core_en}, 32'd0);

        // Async reset mid-RUN, asserted between edges.
        mode = 2'b00;
        repeat (3) edge1();
        check("pre_async_core_en", {31'd0, core_en}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_out_n", {31'd0, rst_out_n}, 32'd0);
        check("async_ready",     {31'd0, ready},     32'd0);
        check("async_core_en",   {31'd0, core_en},   32'd0);
        check("async_tick",      {30'd0, tick},      32'd0);
`ifdef CYCLE_COUNT_EN
        check("async_cycle_count", cycle_count, 32'd0);
`endif
        edge1();
        reset = 1'b1;
        repeat (18) edge1();
        check("rerel_rst_out_n", {31'd0, rst_out_n}, 32'd1);
`ifdef CYCLE_COUNT_EN
        repeat (100) edge1();
        check("cycle_count_100", cycle_count, 32'd100);
        sw_reset_req = 1'b1;
        edge1();
        sw_reset_req = 1'b0;
        check("cycle_count_sw_clr", cycle_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
